// File: rtl/seven_segment_scan_decoder_if.sv
// Multiplexed seven-segment display bus plus the recovered-frame outputs.
// The master drives the scanned display lines and the slave decodes them.
interface seven_segment_scan_decoder_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [6:0]              seg_in;
  logic                    dp_in;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic [4*NUM_DIGITS-1:0] value_out;
  logic [NUM_DIGITS-1:0]   dp_out;
  logic [NUM_DIGITS-1:0]   blank_out;
  logic                    frame_valid;
  logic                    frame_err;

  modport master (
    output seg_in, dp_in, digit_sel,
    input  value_out, dp_out, blank_out, frame_valid, frame_err
  );

  modport slave (
    input  seg_in, dp_in, digit_sel,
    output value_out, dp_out, blank_out, frame_valid, frame_err
  );
endinterface

// File: rtl/seven_segment_scan_decoder.sv
// Recovers hex digits from a scanned seven-segment display bus. A digit is
// captured once its pattern has been stable long enough, and a full frame is published.
module seven_segment_scan_decoder #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input logic                         clk,
  input logic                         rst,
  seven_segment_scan_decoder_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned VAL_W = 4 * NUM_DIGITS;

  typedef struct packed {
    logic [NUM_DIGITS-1:0] sel;
    logic [6:0]            seg;
    logic                  dp;
  } sample_t;

  sample_t               pins_c;
  sample_t               s1_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  stable_c, onehot_c, capture_c, transfer_c;
  logic [3:0]            nib_c;
  logic                  blank_c, err_c;

  logic [NUM_DIGITS-1:0] mask_q, mask_d;
  logic [VAL_W-1:0]      sh_val_q, sh_val_d;
  logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0] sh_blank_q, sh_blank_d;
  logic [NUM_DIGITS-1:0] sh_err_q, sh_err_d;

  logic [VAL_W-1:0]      val_q, val_d;
  logic [NUM_DIGITS-1:0] dp_q, dp_d;
  logic [NUM_DIGITS-1:0] blank_q, blank_d;
  logic                  err_q, err_d;
  logic                  fv_q, fv_d;

  assign pins_c = {bus.digit_sel, bus.seg_in, bus.dp_in};

  // Stability counting: any difference between the pins and the sample restarts it.
  always_comb begin
    stable_c = (pins_c == s1_q);
    cnt_d    = cnt_q;
    if (!stable_c) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_W'(SETTLE_CYCLES)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign onehot_c   = (s1_q.sel != '0) &&
                      ((s1_q.sel & (s1_q.sel - NUM_DIGITS'(1))) == '0);
  assign capture_c  = stable_c && (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) && onehot_c;
  assign transfer_c = &mask_q;

  // Segment pattern (a..g, MSB first) to hex nibble.
  always_comb begin
    nib_c   = 4'h0;
    blank_c = 1'b0;
    err_c   = 1'b0;
    case (s1_q.seg)
      7'h7E: nib_c = 4'h0;
      7'h30: nib_c = 4'h1;
      7'h6D: nib_c = 4'h2;
      7'h79: nib_c = 4'h3;
      7'h33: nib_c = 4'h4;
      7'h5B: nib_c = 4'h5;
      7'h5F: nib_c = 4'h6;
      7'h70: nib_c = 4'h7;
      7'h7F: nib_c = 4'h8;
      7'h7B: nib_c = 4'h9;
      7'h77: nib_c = 4'hA;
      7'h1F: nib_c = 4'hB;
      7'h4E: nib_c = 4'hC;
      7'h3D: nib_c = 4'hD;
      7'h4F: nib_c = 4'hE;
      7'h47: nib_c = 4'hF;
      7'h00: blank_c = 1'b1;
      default: err_c = 1'b1;
    endcase
  end

  // Transfer first, then capture, so a same-edge capture lands in the new frame.
  always_comb begin
    mask_d     = mask_q;
    sh_val_d   = sh_val_q;
    sh_dp_d    = sh_dp_q;
    sh_blank_d = sh_blank_q;
    sh_err_d   = sh_err_q;
    val_d      = val_q;
    dp_d       = dp_q;
    blank_d    = blank_q;
    err_d      = err_q;
    fv_d       = 1'b0;

    if (transfer_c) begin
      val_d   = sh_val_q;
      dp_d    = sh_dp_q;
      blank_d = sh_blank_q;
      err_d   = |sh_err_q;
      fv_d    = 1'b1;
      mask_d  = '0;
    end

    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (capture_c && s1_q.sel[i]) begin
        sh_val_d[4*i +: 4] = nib_c;
        sh_dp_d[i]         = s1_q.dp;
        sh_blank_d[i]      = blank_c;
        sh_err_d[i]        = err_c;
        mask_d[i]          = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= '0;
      cnt_q      <= '0;
      mask_q     <= '0;
      sh_val_q   <= '0;
      sh_dp_q    <= '0;
      sh_blank_q <= '0;
      sh_err_q   <= '0;
      val_q      <= '0;
      dp_q       <= '0;
      blank_q    <= '0;
      err_q      <= 1'b0;
      fv_q       <= 1'b0;
    end else begin
      s1_q       <= pins_c;
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      sh_val_q   <= sh_val_d;
      sh_dp_q    <= sh_dp_d;
      sh_blank_q <= sh_blank_d;
      sh_err_q   <= sh_err_d;
      val_q      <= val_d;
      dp_q       <= dp_d;
      blank_q    <= blank_d;
      err_q      <= err_d;
      fv_q       <= fv_d;
    end
  end

  assign bus.value_out   = val_q;
  assign bus.dp_out      = dp_q;
  assign bus.blank_out   = blank_q;
  assign bus.frame_err   = err_q;
  assign bus.frame_valid = fv_q;

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Directed bench for seven_segment_scan_decoder: table of whole frames plus
// hand sequences for unstable pins, settle boundary, bad digit selects and reset.
module tb_seven_segment_scan_decoder;

  localparam int unsigned ND = 4;
  localparam int unsigned SC = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seven_segment_scan_decoder_if #(.NUM_DIGITS(ND)) bus ();

  seven_segment_scan_decoder #(.NUM_DIGITS(ND), .SETTLE_CYCLES(SC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [3:0][6:0] seg;
    logic [3:0]      dp;
    logic [15:0]     val;
    logic [3:0]      edp;
    logic [3:0]      blank;
    logic            err;
  } vec_t;

  vec_t vecs [7];

  int n_checks  = 0;
  int n_pass    = 0;
  int cycle     = 0;
  int fv_count  = 0;
  int fv_tick   = -1000;
  int fv0;
  int apply3;

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
    if (bus.frame_valid === 1'b1) begin
      fv_count++;
      fv_tick = cycle;
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic drive(logic [3:0] sel, logic [6:0] seg, logic dp, int n);
    bus.digit_sel = sel;
    bus.seg_in    = seg;
    bus.dp_in     = dp;
    repeat (n) tick();
  endtask

  task automatic show(int d, logic [6:0] seg, logic dp, int n);
    drive(4'(1 << d), seg, dp, n);
  endtask

  task automatic check_out(string name, logic [15:0] val, logic [3:0] dp,
                           logic [3:0] blank, logic err);
    check({name, " value"}, 32'(bus.value_out), 32'(val));
    check({name, " dp"},    32'(bus.dp_out),    32'(dp));
    check({name, " blank"}, 32'(bus.blank_out), 32'(blank));
    check({name, " err"},   32'(bus.frame_err), 32'(err));
  endtask

  initial begin
    vecs[0] = '{{7'h79, 7'h6D, 7'h30, 7'h7E}, 4'b0000, 16'h3210, 4'b0000, 4'b0000, 1'b0};
    vecs[1] = '{{7'h77, 7'h01, 7'h7B, 7'h7F}, 4'b0000, 16'hA098, 4'b0000, 4'b0000, 1'b1};
    vecs[2] = '{{7'h47, 7'h4F, 7'h3D, 7'h4E}, 4'b0000, 16'hFEDC, 4'b0000, 4'b0000, 1'b0};
    vecs[3] = '{{7'h47, 7'h47, 7'h00, 7'h47}, 4'b1000, 16'hFF0F, 4'b1000, 4'b0010, 1'b0};
    vecs[4] = '{{7'h00, 7'h00, 7'h00, 7'h00}, 4'b0101, 16'h0000, 4'b0101, 4'b1111, 1'b0};
    vecs[5] = '{{7'h5B, 7'h33, 7'h77, 7'h1F}, 4'b0010, 16'h54AB, 4'b0010, 4'b0000, 1'b0};
    vecs[6] = '{{7'h5F, 7'h70, 7'h3D, 7'h4F}, 4'b0000, 16'h67DE, 4'b0000, 4'b0000, 1'b0};

    bus.digit_sel = '0;
    bus.seg_in    = '0;
    bus.dp_in     = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    check_out("reset", 16'h0000, 4'b0000, 4'b0000, 1'b0);
    check("reset frame_valid", 32'(bus.frame_valid), 32'd0);
    rst = 1'b0;
    tick();

    // Whole frames, each digit held 12 clocks; frame_valid 10 edges after digit3 appears.
    for (int r = 0; r < 7; r++) begin
      fv0 = fv_count;
      for (int d = 0; d < 4; d++) begin
        if (d == 3) apply3 = cycle;
        show(d, vecs[r].seg[d], vecs[r].dp[d], 12);
      end
      check($sformatf("row%0d frame count", r), 32'(fv_count - fv0), 32'd1);
      check($sformatf("row%0d latency", r), 32'(fv_tick - apply3), 32'd10);
      check($sformatf("row%0d pulse end", r), 32'(bus.frame_valid), 32'd0);
      check_out($sformatf("row%0d", r), vecs[r].val, vecs[r].edp, vecs[r].blank, vecs[r].err);
    end

    // Digit0 toggles every 5 clocks: never stable long enough to capture.
    fv0 = fv_count;
    for (int k = 0; k < 20; k++) show(0, (k % 2 == 1) ? 7'h30 : 7'h7E, 1'b0, 5);
    check("toggle no frame", 32'(fv_count - fv0), 32'd0);
    show(1, 7'h30, 1'b0, 12);
    show(2, 7'h6D, 1'b0, 12);
    show(3, 7'h79, 1'b0, 12);
    check("toggle digit0 not captured", 32'(fv_count - fv0), 32'd0);
    show(0, 7'h7E, 1'b0, 12);
    check("toggle then digit0 frame", 32'(fv_count - fv0), 32'd1);
    check_out("toggle frame", 16'h3210, 4'b0000, 4'b0000, 1'b0);

    // Settle boundary: S edges of stability is one short, S+1 captures.
    fv0 = fv_count;
    show(0, 7'h7F, 1'b0, 12);
    show(1, 7'h7B, 1'b0, 12);
    show(2, 7'h77, 1'b0, 12);
    show(3, 7'h1F, 1'b0, 8);
    drive(4'b0000, 7'h00, 1'b0, 12);
    check("hold S edges no capture", 32'(fv_count - fv0), 32'd0);
    show(3, 7'h1F, 1'b1, 9);
    drive(4'b0000, 7'h00, 1'b0, 5);
    check("hold S+1 edges captures", 32'(fv_count - fv0), 32'd1);
    check_out("boundary frame", 16'hBA98, 4'b1000, 4'b0000, 1'b0);

    // Zero and multi-hot digit selects never capture.
    fv0 = fv_count;
    drive(4'b0000, 7'h7E, 1'b0, 50);
    drive(4'b0110, 7'h30, 1'b1, 50);
    show(0, 7'h7E, 1'b0, 12);
    show(3, 7'h79, 1'b0, 12);
    check("bad select no capture", 32'(fv_count - fv0), 32'd0);
    show(1, 7'h4E, 1'b0, 12);
    show(2, 7'h77, 1'b0, 12);
    check("bad select then frame", 32'(fv_count - fv0), 32'd1);
    check_out("bad select frame", 16'h3AC0, 4'b0000, 4'b0000, 1'b0);

    // Reset mid-frame discards digits 0..2; digit3 alone cannot complete a frame.
    fv0 = fv_count;
    show(0, 7'h7F, 1'b0, 12);
    show(1, 7'h7B, 1'b0, 12);
    show(2, 7'h4F, 1'b0, 12);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_out("after reset", 16'h0000, 4'b0000, 4'b0000, 1'b0);
    show(3, 7'h5F, 1'b0, 12);
    check("reset partial no frame", 32'(fv_count - fv0), 32'd0);
    check_out("reset digit3 only", 16'h0000, 4'b0000, 4'b0000, 1'b0);
    show(0, 7'h7F, 1'b0, 12);
    show(1, 7'h7B, 1'b0, 12);
    show(2, 7'h4F, 1'b0, 12);
    show(3, 7'h5F, 1'b0, 12);
    check("post reset one frame", 32'(fv_count - fv0), 32'd1);
    check_out("post reset frame", 16'h6E98, 4'b0000, 4'b0000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
